// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle between the pipeline datapath and pipeline_hazard_ctrl.
// The master modport is the datapath side; the slave modport is the controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_muldiv;
  logic             id_reads_hilo;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             mem_pc_src;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_start;
  logic             md_abort;
  logic             md_busy;
  logic             md_done;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
           ex_mem_read, ex_rt, mem_pc_src,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           md_start, md_abort, md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
           ex_mem_read, ex_rt, mem_pc_src,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           md_start, md_abort, md_busy, md_done
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / HI-LO stall, branch flush and mult/div sequencing for the 5-stage pipeline.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int REG_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz_if
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]            stall_cycles_o,
  output logic [31:0]            flush_events_o
`endif
);

  localparam int CNT_W = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(MD_LATENCY - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mdCnt_q, mdCnt_d;

  logic loadUse;
  logic hiloHaz;
  logic inWait;
  logic stall;
  logic issue;
  logic abort;
  logic done;

  // Hazard detection; a taken branch in MEM squashes the stalled instruction anyway, so it wins.
  always_comb begin
    inWait  = (state_q == MD_WAIT);
    loadUse = hz_if.ex_mem_read && (hz_if.ex_rt != '0) &&
              ((hz_if.ex_rt == hz_if.id_rs) ||
               (hz_if.id_uses_rt && (hz_if.ex_rt == hz_if.id_rt)));
    hiloHaz = inWait && (hz_if.id_reads_hilo || hz_if.id_is_muldiv);
    stall   = (loadUse || hiloHaz) && !hz_if.mem_pc_src;
    issue   = !inWait && hz_if.id_is_muldiv && !loadUse && !hz_if.mem_pc_src;
    abort   = inWait && hz_if.mem_pc_src && (mdCnt_q == CNT_FIRST);
    done    = inWait && (mdCnt_q == '0) && !abort;
  end

  // Outputs are forced to their idle values while reset is held, independent of inputs.
  always_comb begin
    hz_if.pc_write     = 1'b1;
    hz_if.if_id_write  = 1'b1;
    hz_if.if_id_flush  = 1'b0;
    hz_if.id_ex_flush  = 1'b0;
    hz_if.ex_mem_flush = 1'b0;
    hz_if.md_start     = 1'b0;
    hz_if.md_abort     = 1'b0;
    hz_if.md_busy      = 1'b0;
    hz_if.md_done      = 1'b0;
    if (rst_n) begin
      hz_if.pc_write     = !stall;
      hz_if.if_id_write  = !stall;
      hz_if.if_id_flush  = hz_if.mem_pc_src;
      hz_if.id_ex_flush  = stall || hz_if.mem_pc_src;
      hz_if.ex_mem_flush = hz_if.mem_pc_src;
      hz_if.md_start     = issue;
      hz_if.md_abort     = abort;
      hz_if.md_busy      = inWait;
      hz_if.md_done      = done;
    end
  end

  always_comb begin
    state_d = state_q;
    mdCnt_d = mdCnt_q;
    case (state_q)
      RUN: begin
        if (issue) begin
          state_d = MD_WAIT;
          mdCnt_d = CNT_FIRST;
        end
      end
      MD_WAIT: begin
        if (abort || (mdCnt_q == '0)) begin
          state_d = RUN;
          mdCnt_d = '0;
        end else begin
          mdCnt_d = mdCnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        mdCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mdCnt_q <= '0;
    end else begin
      state_q <= state_d;
      mdCnt_q <= mdCnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o <= '0;
      flush_events_o <= '0;
    end else begin
      if (!hz_if.pc_write && (stall_cycles_o != 32'hFFFF_FFFF)) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      if (hz_if.mem_pc_src && (flush_events_o != 32'hFFFF_FFFF)) begin
        flush_events_o <= flush_events_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with MD_LATENCY = 4.
// Output vector order: pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, md_start, md_abort, md_busy, md_done.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  pipeline_hazard_ctrl_if #(.REG_W(5)) hzIf ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles;
  logic [31:0] flushEvents;
`endif

  pipeline_hazard_ctrl #(
    .MD_LATENCY(4),
    .REG_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hz_if(hzIf.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles_o(stallCycles),
    .flush_events_o(flushEvents)
`endif
  );

  logic [8:0] outVec;
  assign outVec = {hzIf.pc_write, hzIf.if_id_write, hzIf.if_id_flush, hzIf.id_ex_flush,
                   hzIf.ex_mem_flush, hzIf.md_start, hzIf.md_abort, hzIf.md_busy, hzIf.md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic isMd, input logic readsHilo, input logic memRead,
                               input logic [4:0] exRt, input logic pcSrc);
    hzIf.id_rs         = rs;
    hzIf.id_rt         = rt;
    hzIf.id_uses_rt    = usesRt;
    hzIf.id_is_muldiv  = isMd;
    hzIf.id_reads_hilo = readsHilo;
    hzIf.ex_mem_read   = memRead;
    hzIf.ex_rt         = exRt;
    hzIf.mem_pc_src    = pcSrc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check the combinational outputs mid-cycle, then advance to just past the next rising edge.
  task automatic runCycle(input string tag, input logic [8:0] expected);
    @(negedge clk);
    checkOutput(tag, {23'd0, outVec}, {23'd0, expected});
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    checkOutput("reset_idle", {23'd0, outVec}, 32'b1_1000_0000);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    #1;
    checkOutput("reset_forced", {23'd0, outVec}, 32'b1_1000_0000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    runCycle("lu_rs", 9'b000100000);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    runCycle("lu_zero_reg", 9'b110000000);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    runCycle("branch_over_lu", 9'b111110000);
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall", stallCycles, 32'd1);
    checkOutput("perf_flush", flushEvents, 32'd1);
`endif
    applyStimulus(5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    runCycle("lu_rt", 9'b000100000);
    applyStimulus(5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    runCycle("rt_unused", 9'b110000000);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    runCycle("issue_blocked_by_lu", 9'b000100000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("no_wait_after_lu", 9'b110000000);

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_issue", 9'b110001000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 3; i++) runCycle("hilo_stall", 9'b000100010);
    runCycle("hilo_stall_done", 9'b000100011);
    runCycle("hilo_advance", 9'b110000000);

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_issue_abort", 9'b110001000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    runCycle("md_abort", 9'b111110110);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("after_abort", 9'b110000000);

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_issue_late", 9'b110001000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_busy1", 9'b110000010);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    runCycle("late_branch", 9'b111110010);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_busy3", 9'b110000010);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    runCycle("md_done_hold", 9'b000100011);
    runCycle("md_reissue", 9'b110001000);

    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    runCycle("busy_after_reissue", 9'b000100010);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {23'd0, outVec}, 32'b1_1000_0000);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", {23'd0, outVec}, 32'b1_1000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    runCycle("run_after_reset", 9'b110000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
